// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 red/green LED matrix frame store and scan sequencer.
// Pure type/constant package; no logic, no latency, no flow control.
package led_matrix_pkg;

    localparam int NUM_ROWS = 8;

    typedef logic [2:0]      row_t;
    typedef logic [7:0][7:0] frame_t;
    typedef logic [7:0]      row_bits_t;

endpackage

// File: rtl/scan_divider.sv
// Scan clock divider and row tracker: scan_clk toggles every DIV clk, row_idx steps on each rise.
// scan_rise is combinational and marks the cycle whose closing edge raises scan_clk; no backpressure.
module scan_divider
    import led_matrix_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic reset_n,
    output logic scan_clk,
    output logic scan_rise,
    output row_t row_idx
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          scan_clk_q, scan_clk_d;
    row_t          row_idx_q, row_idx_d;
    logic          wrap;

    always_comb begin
        wrap       = (div_cnt_q == CNT_MAX);
        div_cnt_d  = wrap ? '0 : div_cnt_q + 1'b1;
        scan_clk_d = scan_clk_q ^ wrap;
        scan_rise  = wrap & ~scan_clk_q;
        row_idx_d  = scan_rise ? row_idx_q + 3'd1 : row_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            scan_clk_q <= 1'b0;
            row_idx_q  <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_clk_q <= scan_clk_d;
            row_idx_q  <= row_idx_d;
        end
    end

    assign scan_clk = scan_clk_q;
    assign row_idx  = row_idx_q;

endmodule

// File: rtl/led_frame_controller.sv
// Double-buffered 8x8 frame store: arbitrated row writes to back, back->front copy at frame boundary.
// Writes land one edge after grant; grants drop in the swap cycle so requesters simply hold and retry.
module led_frame_controller
    import led_matrix_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      wr_req,
    input  row_t [1:0]      wr_row,
    input  row_bits_t [1:0] wr_red,
    input  row_bits_t [1:0] wr_green,
    output logic [1:0]      wr_gnt,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_done,
    output logic            scan_clk,
    output frame_t          red_array,
    output frame_t          green_array
);

    logic   scan_rise;
    row_t   row_idx;
    logic   frame_boundary, swap;
    logic   wr_sel;

    frame_t back_red_q, back_red_d, back_green_q, back_green_d;
    frame_t front_red_q, front_red_d, front_green_q, front_green_d;
    logic   pending_q, pending_d;
    logic   frame_done_q, frame_done_d;

    scan_divider #(.DIV(DIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .scan_clk  (scan_clk),
        .scan_rise (scan_rise),
        .row_idx   (row_idx)
    );

    // The boundary is the rise that takes the driver from row 7 back to row 0.
    assign frame_boundary = scan_rise & (row_idx == row_t'(NUM_ROWS - 1));
    assign swap           = frame_boundary & pending_q;

    // Gated by reset_n so the combinational grant also reads 0 while reset is held.
    assign wr_gnt[0] = reset_n & ~swap & wr_req[0];
    assign wr_gnt[1] = reset_n & ~swap & wr_req[1] & ~wr_req[0];
    assign wr_sel    = wr_gnt[1];

    always_comb begin
        back_red_d    = back_red_q;
        back_green_d  = back_green_q;
        front_red_d   = front_red_q;
        front_green_d = front_green_q;
        pending_d     = (pending_q & ~swap) | commit;
        frame_done_d  = swap;
        if (|wr_gnt) begin
            back_red_d[wr_row[wr_sel]]   = wr_red[wr_sel];
            back_green_d[wr_row[wr_sel]] = wr_green[wr_sel];
        end
        if (swap) begin
            front_red_d   = back_red_q;
            front_green_d = back_green_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            back_red_q    <= '0;
            back_green_q  <= '0;
            front_red_q   <= '0;
            front_green_q <= '0;
            pending_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            back_red_q    <= back_red_d;
            back_green_q  <= back_green_d;
            front_red_q   <= front_red_d;
            front_green_q <= front_green_d;
            pending_q     <= pending_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign commit_pending = pending_q;
    assign frame_done     = frame_done_q;
    assign red_array      = front_red_q;
    assign green_array    = front_green_q;

endmodule

// File: tb/tb_led_frame_controller.sv
// Directed bench for led_frame_controller at DIV=2 (scan period 4 clk, frame 32 clk).
// Edge counter ecnt tracks posedges since reset release; boundary edges satisfy ecnt % 32 == 30.
module tb_led_frame_controller;

    logic            clk;
    logic            reset_n;
    logic [1:0]      wr_req;
    logic [1:0][2:0] wr_row;
    logic [1:0][7:0] wr_red;
    logic [1:0][7:0] wr_green;
    logic [1:0]      wr_gnt;
    logic            commit;
    logic            commit_pending;
    logic            frame_done;
    logic            scan_clk;
    logic [7:0][7:0] red_array;
    logic [7:0][7:0] green_array;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt;

    led_frame_controller #(.DIV(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_req         (wr_req),
        .wr_row         (wr_row),
        .wr_red         (wr_red),
        .wr_green       (wr_green),
        .wr_gnt         (wr_gnt),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .scan_clk       (scan_clk),
        .red_array      (red_array),
        .green_array    (green_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ecnt <= 0;
        else          ecnt <= ecnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge 29 of a frame: the next edge is the boundary.
    task automatic goto_pre_boundary();
        int n;
        n = 0;
        while ((ecnt % 32) != 29 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    logic [63:0] exp_red, exp_green;
    int          fd_count;

    initial begin
        reset_n  = 1'b0;
        wr_req   = 2'b00;
        wr_row   = '0;
        wr_red   = '0;
        wr_green = '0;
        commit   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_gnt",     {62'd0, wr_gnt}, 64'd0);
        check("rst_pending", {63'd0, commit_pending}, 64'd0);
        check("rst_fdone",   {63'd0, frame_done}, 64'd0);
        check("rst_sclk",    {63'd0, scan_clk}, 64'd0);
        check("rst_red",     red_array, 64'd0);
        check("rst_green",   green_array, 64'd0);
        check("rst_row",     {61'd0, dut.u_div.row_idx}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Scan clock and row tracking over one frame plus a few edges
        for (int n = 1; n <= 34; n++) begin
            step();
            check($sformatf("sclk_e%0d", n), {63'd0, scan_clk}, 64'((n / 2) % 2));
            check($sformatf("row_e%0d", n), {61'd0, dut.u_div.row_idx}, 64'(((n + 2) / 4) % 8));
            check($sformatf("fd_e%0d", n), {63'd0, frame_done}, 64'd0);
        end

        // Requester 0 writes row 3, commit mid-frame
        wr_req    = 2'b01;
        wr_row[0] = 3'd3;
        wr_red[0] = 8'hA5;
        wr_green[0] = 8'h00;
        #1;
        check("w0_gnt", {62'd0, wr_gnt}, 64'h1);
        step();
        wr_req = 2'b00;
        check("w0_nopend", {63'd0, commit_pending}, 64'd0);
        pulse_commit();
        check("w0_pend", {63'd0, commit_pending}, 64'd1);
        check("w0_front_hold", red_array, 64'd0);
        goto_pre_boundary();
        check("w0_pend_pre", {63'd0, commit_pending}, 64'd1);
        check("w0_front_pre", red_array, 64'd0);
        step();
        exp_red = 64'h00000000_A5000000;
        check("w0_red_swap", red_array, exp_red);
        check("w0_green_swap", green_array, 64'd0);
        check("w0_fd_hi", {63'd0, frame_done}, 64'd1);
        check("w0_pend_clr", {63'd0, commit_pending}, 64'd0);
        check("w0_row0", {61'd0, dut.u_div.row_idx}, 64'd0);
        step();
        check("w0_fd_lo", {63'd0, frame_done}, 64'd0);

        // Simultaneous requests: requester 0 first, requester 1 next cycle
        wr_req      = 2'b11;
        wr_row[0]   = 3'd1;
        wr_red[0]   = 8'h11;
        wr_green[0] = 8'h22;
        wr_row[1]   = 3'd6;
        wr_red[1]   = 8'h33;
        wr_green[1] = 8'h44;
        #1;
        check("arb_gnt0", {62'd0, wr_gnt}, 64'h1);
        step();
        wr_req = 2'b10;
        #1;
        check("arb_gnt1", {62'd0, wr_gnt}, 64'h2);
        step();
        wr_req = 2'b00;
        check("arb_front_hold", red_array, exp_red);
        pulse_commit();
        goto_pre_boundary();
        step();
        exp_red   = 64'h00330000_A5001100;
        exp_green = 64'h00440000_00002200;
        check("arb_red", red_array, exp_red);
        check("arb_green", green_array, exp_green);
        check("arb_fd", {63'd0, frame_done}, 64'd1);

        // Three commit pulses before one boundary: one swap only
        step();
        for (int k = 0; k < 3; k++) begin
            pulse_commit();
            step();
        end
        check("merge_pend", {63'd0, commit_pending}, 64'd1);
        fd_count = 0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (frame_done) fd_count++;
        end
        check("merge_fd_count", 64'(fd_count), 64'd1);
        check("merge_pend_end", {63'd0, commit_pending}, 64'd0);

        // Write and commit in the swap cycle
        pulse_commit();
        goto_pre_boundary();
        wr_req      = 2'b01;
        wr_row[0]   = 3'd5;
        wr_red[0]   = 8'h77;
        wr_green[0] = 8'h88;
        commit      = 1'b1;
        #1;
        check("swp_gnt_blocked", {62'd0, wr_gnt}, 64'h0);
        step();
        commit = 1'b0;
        check("swp_pend_reset", {63'd0, commit_pending}, 64'd1);
        check("swp_fd", {63'd0, frame_done}, 64'd1);
        check("swp_red_nochg", red_array, exp_red);
        #1;
        check("swp_gnt_retry", {62'd0, wr_gnt}, 64'h1);
        step();
        wr_req = 2'b00;
        check("swp_red_defer", red_array, exp_red);
        goto_pre_boundary();
        check("swp_red_pre", red_array, exp_red);
        step();
        exp_red   = 64'h00337700_A5001100;
        exp_green = 64'h00448800_00002200;
        check("swp_red_next", red_array, exp_red);
        check("swp_green_next", green_array, exp_green);
        check("swp_pend_done", {63'd0, commit_pending}, 64'd0);

        // Fill front with 8'hFF via requester 1, then async reset mid-frame
        wr_req = 2'b10;
        for (int r = 0; r < 8; r++) begin
            wr_row[1]   = 3'(r);
            wr_red[1]   = 8'hFF;
            wr_green[1] = 8'hFF;
            step();
        end
        wr_req = 2'b00;
        pulse_commit();
        goto_pre_boundary();
        step();
        check("ff_red", red_array, 64'hFFFFFFFF_FFFFFFFF);
        check("ff_green", green_array, 64'hFFFFFFFF_FFFFFFFF);
        pulse_commit();
        for (int n = 0; n < 4 && (ecnt % 4) != 2; n++) step();
        check("ar_sclk_pre", {63'd0, scan_clk}, 64'd1);
        wr_req = 2'b01;
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_red", red_array, 64'd0);
        check("ar_green", green_array, 64'd0);
        check("ar_sclk", {63'd0, scan_clk}, 64'd0);
        check("ar_pend", {63'd0, commit_pending}, 64'd0);
        check("ar_gnt", {62'd0, wr_gnt}, 64'd0);
        check("ar_fd", {63'd0, frame_done}, 64'd0);
        wr_req = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulse_commit();
        goto_pre_boundary();
        step();
        check("ar_back_clr_fd", {63'd0, frame_done}, 64'd1);
        check("ar_back_clr_red", red_array, 64'd0);
        check("ar_back_clr_green", green_array, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
